// File: rtl/gbfflgwei_reader_if.sv
// Bus bundle for the flag/weight global-buffer reader: burst config, RAM read port
// and the PE-side valid/ready stream.
interface gbfflgwei_reader_if #(
   parameter int SRAM_DEPTH_BIT = 6,
   parameter int SRAM_WIDTH     = 28,
   parameter int LEN_BIT        = SRAM_DEPTH_BIT + 1
);
   logic                      cfg_start;
   logic [SRAM_DEPTH_BIT-1:0] cfg_base;
   logic [LEN_BIT-1:0]        cfg_len;
   logic                      cfg_idle;
   logic                      done;
   logic                      wr_busy;
   logic                      ram_read_en;
   logic [SRAM_DEPTH_BIT-1:0] ram_addr_r;
   logic [SRAM_WIDTH-1:0]     ram_data_out;
   logic [SRAM_WIDTH-1:0]     out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic                      out_last;

   modport master (
      input  cfg_start, cfg_base, cfg_len, wr_busy, ram_data_out, out_ready,
      output cfg_idle, done, ram_read_en, ram_addr_r, out_data, out_valid, out_last
   );

   modport slave (
      output cfg_start, cfg_base, cfg_len, wr_busy, ram_data_out, out_ready,
      input  cfg_idle, done, ram_read_en, ram_addr_r, out_data, out_valid, out_last
   );
endinterface

// File: rtl/gbfflgwei_reader.sv
// Burst reader for the flag/weight global buffer: issues credit-limited RAM reads,
// captures at 1-cycle latency into a 2-entry FIFO and streams words with a last marker.
//
// state | meaning
// IDLE  | waiting for cfg_start; cfg_idle=1
// RUN   | issuing reads and streaming words until the last word handshakes
// FIN   | one-cycle done pulse, then back to IDLE
module gbfflgwei_reader #(
   parameter int SRAM_DEPTH_BIT = 6,
   parameter int SRAM_WIDTH     = 28,
   parameter int LEN_BIT        = SRAM_DEPTH_BIT + 1
) (
   input logic                clk,
   input logic                rst,
   gbfflgwei_reader_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                    state, state_nxt;
   logic [SRAM_DEPTH_BIT-1:0] addr;
   logic [LEN_BIT-1:0]        rem_issue;
   logic [LEN_BIT-1:0]        rem_out;
   logic                      inflight;
   logic [SRAM_WIDTH-1:0]     fifo_mem [2];
   logic                      rd_ptr;
   logic                      wr_ptr;
   logic [1:0]                occ;
   logic                      accept;
   logic                      issue;
   logic                      pop;
   logic [2:0]                credit_used;

   assign accept      = bus.cfg_start && (state == IDLE);
   assign pop         = bus.out_valid && bus.out_ready;
   assign credit_used = {1'b0, occ} + {2'b00, inflight};

   // A read may only go out if its word is guaranteed a FIFO slot on arrival.
   assign issue = (state == RUN) && (rem_issue != '0) && !bus.wr_busy &&
                  (credit_used < (3'd2 + {2'b00, pop}));

   assign bus.ram_read_en = issue;
   assign bus.ram_addr_r  = addr;
   assign bus.out_valid   = (occ != 2'd0);
   assign bus.out_data    = fifo_mem[rd_ptr];
   assign bus.out_last    = bus.out_valid && (rem_out == LEN_BIT'(1));

   always_comb begin
      state_nxt    = state;
      bus.cfg_idle = 1'b0;
      bus.done     = 1'b0;
      case (state)
         IDLE: begin
            bus.cfg_idle = 1'b1;
            if (bus.cfg_start) state_nxt = (bus.cfg_len == '0) ? FIN : RUN;
         end
         RUN: begin
            if (pop && bus.out_last) state_nxt = FIN;
         end
         FIN: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr        <= '0;
         rem_issue   <= '0;
         rem_out     <= '0;
         inflight    <= 1'b0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         occ         <= 2'd0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (accept) begin
            addr      <= bus.cfg_base;
            rem_issue <= bus.cfg_len;
            rem_out   <= bus.cfg_len;
         end else begin
            if (issue) begin
               addr      <= addr + SRAM_DEPTH_BIT'(1);
               rem_issue <= rem_issue - LEN_BIT'(1);
            end
            if (pop) rem_out <= rem_out - LEN_BIT'(1);
         end
         // RAM data is only valid the cycle after the strobe; capture it then.
         if (inflight) begin
            fifo_mem[wr_ptr] <= bus.ram_data_out;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({inflight, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end
endmodule

// File: tb/tb_gbfflgwei_reader.sv
// Randomized bench for gbfflgwei_reader: a transaction-level model of the burst
// (word index, credit count, arrival delay) is compared against the DUT every cycle.
module tb_gbfflgwei_reader;
   localparam int DB    = 6;
   localparam int W     = 28;
   localparam int LB    = DB + 1;
   localparam int DEPTH = 1 << DB;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gbfflgwei_reader_if #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W), .LEN_BIT(LB)) bus ();

   gbfflgwei_reader #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W), .LEN_BIT(LB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [W-1:0] mem [DEPTH];

   // RAM with 1-cycle read latency; garbage on the bus when not reading.
   always @(posedge clk)
      bus.ram_data_out <= bus.ram_read_en ? mem[bus.ram_addr_r] : W'($urandom);

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: burst as word indices; a read word becomes visible two cycles after issue.
   bit           m_idle = 1'b1, m_run = 1'b0, m_fin = 1'b0, post_rst = 1'b0;
   int           m_base = 0, m_len = 0, m_issued = 0, m_popped = 0, m_avail = 0, m_stage = 0;
   int           dut_iss = 0, dut_pop = 0;
   bit           prev_stall = 1'b0;
   logic [W-1:0] prev_data;

   always @(negedge clk) begin
      bit ev, ei, pp;
      if (post_rst) begin
         chk("rst_cfg_idle", bus.cfg_idle, 1);
         chk("rst_done", bus.done, 0);
         chk("rst_rd_en", bus.ram_read_en, 0);
         chk("rst_valid", bus.out_valid, 0);
         chk("rst_last", bus.out_last, 0);
         chk("rst_addr", bus.ram_addr_r, 0);
         chk("rst_data", bus.out_data, 0);
         post_rst = 1'b0;
      end
      ev = m_run && (m_avail > 0);
      pp = ev && bus.out_ready;
      ei = m_run && (m_issued < m_len) && !bus.wr_busy && (m_issued - m_popped - pp < 2);

      chk("cfg_idle", bus.cfg_idle, m_idle);
      chk("done", bus.done, m_fin);
      chk("rd_en", bus.ram_read_en, ei);
      if (ei) chk("rd_addr", bus.ram_addr_r, (m_base + m_issued) % DEPTH);
      chk("out_valid", bus.out_valid, ev);
      if (ev) begin
         chk("out_data", bus.out_data, mem[(m_base + m_popped) % DEPTH]);
         chk("out_last", bus.out_last, (m_popped == m_len - 1));
      end else begin
         chk("out_last_novalid", bus.out_last, 0);
      end
      chk("rd_vs_wr", bus.ram_read_en & bus.wr_busy, 0);
      if (prev_stall) begin
         chk("stall_valid", bus.out_valid, 1);
         chk("stall_data", bus.out_data, prev_data);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      dut_iss += int'(bus.ram_read_en);
      dut_pop += int'(bus.out_valid && bus.out_ready);
      chk("fifo_overflow", (dut_iss - dut_pop) > 2, 0);

      if (rst) begin
         m_idle = 1'b1; m_run = 1'b0; m_fin = 1'b0;
         m_issued = 0; m_popped = 0; m_avail = 0; m_stage = 0;
         dut_iss = 0; dut_pop = 0; prev_stall = 1'b0; post_rst = 1'b1;
      end else if (m_fin) begin
         m_fin  = 1'b0;
         m_idle = 1'b1;
      end else if (m_idle) begin
         if (bus.cfg_start) begin
            m_base = int'(bus.cfg_base); m_len = int'(bus.cfg_len);
            m_issued = 0; m_popped = 0; m_avail = 0; m_stage = 0;
            dut_iss = 0; dut_pop = 0;
            m_idle = 1'b0;
            if (m_len == 0) m_fin = 1'b1;
            else            m_run = 1'b1;
         end
      end else if (m_run) begin
         m_avail   = m_avail - int'(pp) + m_stage;
         m_stage   = int'(ei);
         m_issued += int'(ei);
         if (pp) begin
            m_popped++;
            if (m_popped == m_len) begin
               m_run = 1'b0;
               m_fin = 1'b1;
            end
         end
      end
   end

   int p_ready = 100, p_busy = 0;
   bit busy_toggle = 1'b0, noise = 1'b0;

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 99) < p_ready);
      bus.wr_busy   = busy_toggle ? ~bus.wr_busy : ($urandom_range(0, 99) < p_busy);
      if (noise && m_run) begin
         bus.cfg_start = ($urandom_range(0, 3) == 0);
         bus.cfg_base  = DB'($urandom);
         bus.cfg_len   = LB'($urandom_range(0, 64));
      end else begin
         bus.cfg_start = 1'b0;
      end
   endtask

   task automatic start_burst(input int base, input int len);
      cyc();
      bus.cfg_start = 1'b1;
      bus.cfg_base  = DB'(base);
      bus.cfg_len   = LB'(len);
      cyc();
   endtask

   task automatic wait_idle(input int maxc);
      int k = 0;
      while (!(m_idle && bus.cfg_idle) && k < maxc) begin
         cyc();
         k++;
      end
      chk("burst_timeout", bus.cfg_idle, 1);
   endtask

   bit lit_rd    [7] = '{1, 1, 1, 1, 0, 0, 0};
   int lit_addr  [7] = '{5, 6, 7, 8, 0, 0, 0};
   bit lit_valid [7] = '{0, 0, 1, 1, 1, 1, 0};
   int lit_data  [7] = '{0, 0, 5, 6, 7, 8, 0};
   bit lit_last  [7] = '{0, 0, 0, 0, 0, 1, 0};
   bit lit_done  [7] = '{0, 0, 0, 0, 0, 0, 1};

   initial begin
      int idx;
      rst = 1'b1;
      bus.cfg_start = 1'b0; bus.cfg_base = '0; bus.cfg_len = '0;
      bus.wr_busy = 1'b0; bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
      repeat (3) cyc();
      rst = 1'b0;
      cyc();

      // Basic burst pinned with literal expectations, cycle by cycle after the accept edge.
      start_burst(5, 4);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk("lit_rd_en", bus.ram_read_en, lit_rd[c]);
         if (lit_rd[c]) chk("lit_rd_addr", bus.ram_addr_r, lit_addr[c]);
         chk("lit_valid", bus.out_valid, lit_valid[c]);
         if (lit_valid[c]) chk("lit_data", bus.out_data, lit_data[c]);
         chk("lit_last", bus.out_last, lit_last[c]);
         chk("lit_done", bus.done, lit_done[c]);
         cyc();
      end
      wait_idle(50);

      // Wrap around the top of the address space.
      start_burst(62, 4);
      @(negedge clk);
      chk("wrap_first_addr", bus.ram_addr_r, 62);
      wait_idle(50);

      // Backpressure: consumer stalls during cycles 4..9 after the accept edge.
      start_burst(12, 6);
      idx = 1;
      while (!(m_idle && bus.cfg_idle) && idx < 60) begin
         cyc();
         idx++;
         bus.out_ready = (idx < 4 || idx > 9);
         if (idx == 10) begin
            chk("bp_reads_held", dut_iss, 3);
            chk("bp_pops_held", dut_pop, 1);
         end
      end
      wait_idle(50);

      // Write collisions on every other cycle.
      busy_toggle = 1'b1;
      start_burst(33, 8);
      wait_idle(100);
      busy_toggle = 1'b0;
      bus.wr_busy = 1'b0;

      // Zero length: immediate done, no reads.
      start_burst(7, 0);
      @(negedge clk);
      chk("zero_done", bus.done, 1);
      chk("zero_rd_en", bus.ram_read_en, 0);
      chk("zero_cfg_idle", bus.cfg_idle, 0);
      wait_idle(20);

      // Start pulse mid-burst must be ignored.
      start_burst(10, 5);
      cyc();
      bus.cfg_start = 1'b1; bus.cfg_base = DB'(40); bus.cfg_len = LB'(2);
      cyc();
      wait_idle(50);

      // Reset after two words delivered, then a fresh burst.
      start_burst(20, 6);
      idx = 0;
      while (dut_pop < 2 && idx < 100) begin
         cyc();
         idx++;
      end
      chk("rst_wait_two_words", dut_pop >= 2, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      start_burst(30, 3);
      wait_idle(50);

      // Randomized bursts with random data, stalls, write traffic and stray starts.
      noise = 1'b1;
      for (int b = 0; b < 20; b++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
         p_ready = $urandom_range(30, 100);
         p_busy  = $urandom_range(0, 50);
         start_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 64));
         wait_idle(2000);
      end
      noise = 1'b0;
      p_ready = 100;
      p_busy = 0;
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end
endmodule

// File: doc/gbfflgwei_reader.md
Name: gbfflgwei_reader

Overview:
- Read-side initiator for the flag/weight global-buffer RAM wrapper.
- Accepts a burst request (base address, word count) and issues single-cycle read strobes to the RAM.
- Captures RAM output at the fixed 1-cycle latency and streams words to the PE-side consumer over a valid/ready handshake with a last marker.
- Yields the shared single-port address to the write side; write has priority.

Parameters:
- SRAM_DEPTH_BIT, 6, RAM address width; depth = 2**SRAM_DEPTH_BIT.
- SRAM_WIDTH, 28, RAM word width.
- LEN_BIT, SRAM_DEPTH_BIT+1, burst-length width; allows a full-depth burst.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_start  in  1  burst request pulse; accepted only when cfg_idle=1.
- cfg_base  in  SRAM_DEPTH_BIT  first read address, sampled with accepted cfg_start.
- cfg_len  in  LEN_BIT  number of words, sampled with accepted cfg_start.
- cfg_idle  out  1  high in IDLE.
- done  out  1  one-cycle pulse at burst completion.
- wr_busy  in  1  RAM write_en is active this cycle; no read may be issued.
- ram_read_en  out  1  RAM read strobe.
- ram_addr_r  out  SRAM_DEPTH_BIT  RAM read address.
- ram_data_out  in  SRAM_WIDTH  RAM read data, valid the cycle after ram_read_en.
- out_data  out  SRAM_WIDTH  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_last  out  1  qualifies the final word of a burst.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - cfg_idle=1.
  - done, ram_read_en, out_valid and out_last are 0.
  - ram_addr_r=0, out_data=0.
  - FIFO is emptied; in-flight read is discarded.
  - Reset mid-burst aborts the burst with no done pulse.
- FSM states:
  - IDLE: accepted cfg_start with cfg_len>0 goes to RUN; it latches addr=cfg_base and rem_issue=rem_out=cfg_len.
  - IDLE: accepted cfg_start with cfg_len=0 goes to FIN; no reads are issued.
  - RUN: goes to FIN on the edge where the word carrying out_last handshakes.
  - FIN: done=1 for exactly this cycle, then IDLE. cfg_idle=0 in FIN.
- cfg_start while not idle is ignored; latched config is unchanged.
- Read issue (combinational in RUN), all conditions required:
  - rem_issue>0
  - wr_busy=0
  - occ + inflight - pop < 2
  - occ = FIFO occupancy (0..2); inflight = read issued last cycle (0/1); pop = out_valid & out_ready.
  - When issued: ram_read_en=1, ram_addr_r=addr.
  - Next edge: addr increments modulo 2**SRAM_DEPTH_BIT (wraps 63->0 at default); rem_issue decrements.
  - ram_read_en is never high when wr_busy=1.
- Capture:
  - inflight is a register.
  - When inflight=1, ram_data_out is pushed into the 2-entry FIFO at the end of that cycle.
  - ram_data_out is sampled only in that cycle.
- Output:
  - FIFO head drives out_data and out_valid.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - out_last=1 when the head word is the final word, i.e. rem_out=1.
  - rem_out decrements on each handshake.
- Simultaneous push and pop in one cycle: occupancy is unchanged; order is preserved.
- FIFO never overflows; the credit rule guarantees it. Overflow is a design error and the bench must assert on it.
- Latency:
  - cfg_start accepted at edge E0.
  - First ram_read_en in the cycle after E0 (if wr_busy=0).
  - First out_valid two cycles after that read.
- Throughput: 1 word/cycle with out_ready=1 and wr_busy=0.
- done: one cycle after the last handshake; next cfg_start can be accepted in the cycle after done.

Test Plan:
- Basic burst: cfg_base=5, cfg_len=4, out_ready=1, wr_busy=0, RAM preloaded mem[i]=i -> reads at addrs 5,6,7,8 on consecutive cycles; out_data 5,6,7,8 on consecutive cycles starting 3 cycles after start; out_last only with 8; done 1 cycle later.
- Wrap: cfg_base=62, cfg_len=4 -> addresses 62,63,0,1; data in that order.
- Backpressure: cfg_len=6, out_ready low for cycles 4..9 -> at most 2 reads outstanding beyond consumed words; no word lost or duplicated; out_data stable while stalled; all 6 words delivered in order.
- Write collision: wr_busy=1 during every other cycle of an 8-word burst -> ram_read_en never coincides with wr_busy; 8 correct words delivered.
- Zero length and ignored start: cfg_len=0 -> no ram_read_en; done pulse in the cycle after the accepting edge. A second cfg_start mid-burst -> ignored; the burst completes with its original config.
- Reset mid-burst: assert rst after 2 of 6 words delivered -> next cycle all outputs at reset values, cfg_idle=1, no done. A following burst of cfg_len=3 runs correctly.
